ofdm_rx_ctrl: RTL
=================

# ofdm_rx_ctrl

Receive-path scheduler for one OFDM symbol. It starts the FFT engine on a frame trigger, then hands the shared FFT-result BSRAM port to the demodulator and starts it. It latches each successful 96-bit demodulated frame into a valid/ready output register and keeps timeout, drop and error statistics. It sits between the frame-sync detector, the FFT engine, the single-port fft0 BSRAM and the demodulator.

## Interface
- TIMEOUT_CYCLES, 16'd50000, per-phase watchdog limit in clk cycles, minimum 2
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- trigger  in  1  frame-sync pulse; start a symbol
- err_clear  in  1  clears sticky err_timeout and overflow
- fft_start  out  1  one-cycle start pulse to FFT engine
- fft_done  in  1  FFT completion pulse
- fft_ce, fft_oce, fft_wre  in  1  FFT-side BSRAM controls
- fft_ad  in  11  FFT-side BSRAM address
- fft_din  in  32  FFT-side write data
- dem_start  out  1  one-cycle start pulse to demodulator
- dem_finish, dem_success  in  1  demodulator status; held until cleared
- dem_res  in  96  demodulated bits
- dem_clear  out  1  one-cycle clear to demodulator
- dem_ce, dem_oce  in  1  demod-side BSRAM controls
- dem_ad  in  11  demod-side BSRAM address
- ram_ce, ram_oce, ram_wre  out  1  BSRAM port controls
- ram_ad  out  11  BSRAM address
- ram_din  out  32  BSRAM write data
- busy  out  1  state != IDLE
- frame_valid  out  1  frame_data holds an unconsumed frame
- frame_ready  in  1  consumer accepts frame_data
- frame_data  out  96  last successful frame
- err_timeout, overflow  out  1  sticky error flags
- ok_cnt, err_cnt  out  16  successful and failed symbols, wrap mod 2^16
- drop_cnt  out  8  ignored triggers, saturates at 255

## Operation
- All outputs reset to 0. The state machine resets to IDLE. The watchdog timer (16 bit) resets to 0.
- States: IDLE, FFT_RUN, DEM_RUN, CLEAR.
- IDLE
  - trigger=1 → fft_start=1 for the next cycle only, timer←0, go to FFT_RUN.
- FFT_RUN
  - timer increments every cycle.
  - fft_done=1 → dem_start=1 for one cycle, timer←0, go to DEM_RUN.
  - Otherwise, timer==TIMEOUT_CYCLES-1 → err_timeout←1, go to IDLE.
- DEM_RUN
  - timer increments every cycle.
  - dem_finish=1 with dem_success=1 → frame_data←dem_res, frame_valid←1, ok_cnt+1.
  - dem_finish=1 with dem_success=0 → err_cnt+1.
  - Either dem_finish case → go to CLEAR.
  - Timeout as in FFT_RUN: err_timeout←1, dem_clear pulse, go to IDLE.
- CLEAR
  - dem_clear=1 for this one cycle, then go to IDLE.
- BSRAM ownership, combinational on the state register:
  - FFT_RUN: ram_* = fft_* (ram_din = fft_din).
  - DEM_RUN: ram_ce/oce/ad = dem_*, ram_wre=0, ram_din=0.
  - IDLE and CLEAR: all ram_* = 0.
- trigger=1 in any state other than IDLE → drop_cnt+1 (saturating); the trigger is otherwise ignored.
- fft_done outside FFT_RUN and dem_finish outside DEM_RUN are ignored.
- Output handshake
  - frame_valid&&frame_ready → frame_valid←0.
  - New success while frame_valid=1 and frame_ready=0 → keep old frame_data, overflow←1.
  - New success in the same cycle as frame_valid&&frame_ready → load new data, frame_valid stays 1, no overflow.
- err_clear=1 clears err_timeout and overflow. If a set event occurs in the same cycle, the set wins.

## Timing
- trigger sampled at edge N → fft_start high during cycle N+1, busy high from N+1.
- fft_done sampled at N → dem_start high during N+1. BSRAM ownership switches to the demodulator in the same cycle.
- dem_finish sampled at N:
  - frame_valid, frame_data and counters update at N+1.
  - dem_clear high during N+1.
  - IDLE at N+2; a trigger is accepted at N+2 at the earliest.
- Timeout fires exactly TIMEOUT_CYCLES cycles after phase entry if no completion arrives. A completion and a timeout in the same cycle resolve as completion.
- rst_n asserted mid-symbol returns immediately to IDLE:
  - All ram_* drop to 0 asynchronously.
  - frame_valid clears and counters zero.

## Test plan
- Nominal symbol: trigger; fft_done 100 cycles later; dem_finish=1, dem_success=1, dem_res=96'h55…55 → one fft_start, one dem_start, frame_valid=1 with that data, ok_cnt=1, dem_clear pulse, busy low 2 cycles after finish.
- Port mux: during FFT_RUN, drive fft_ad=11'h123, fft_wre=1 → ram_ad=11'h123, ram_wre=1; during DEM_RUN, drive dem_ad=11'h014 → ram_ad=11'h014, ram_wre=0; in IDLE, ram_*=0.
- Failure and timeout: dem_success=0 → err_cnt=1, frame_valid unchanged. With TIMEOUT_CYCLES=16 and no fft_done → err_timeout=1, IDLE at cycle 16; err_clear → 0.
- Overflow: two successful symbols with frame_ready=0 → frame_data is the first frame, overflow=1. Ready and second success coincident → second frame loaded, frame_valid=1, overflow=0.
- Dropped triggers: 300 triggers while busy → drop_cnt=255. Trigger at finish+2 is accepted.
- Async reset during DEM_RUN → ram_ce=0 immediately, state IDLE, all counters 0.

Source files
------------

// File: rtl/ofdm_rx_ctrl.sv
// ofdm_rx_ctrl
// Receive-path scheduler for one OFDM symbol. A frame-sync trigger starts the
// FFT engine. When the FFT completes, the shared fft0 BSRAM port is handed to
// the demodulator and the demodulator is started. A successful 96-bit result
// is latched into a valid/ready output register. The block also keeps timeout,
// overflow, drop and success/failure statistics.
//
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   i_trigger            frame-sync pulse (ignored and counted while busy)
//   i_err_clear          clears the sticky o_err_timeout / o_overflow flags
//   o_fft_start          one-cycle FFT start pulse
//   i_fft_done           FFT completion pulse
//   i_fft_*              FFT-side BSRAM controls, address and write data
//   o_dem_start          one-cycle demodulator start pulse
//   i_dem_finish/success demodulator status, held until o_dem_clear
//   i_dem_res            96-bit demodulated frame
//   o_dem_clear          one-cycle demodulator clear pulse
//   i_dem_*              demod-side BSRAM controls and address (read only)
//   o_ram_*              muxed BSRAM port, driven from the current owner
//   o_busy               scheduler is not idle
//   o_frame_valid/ready  output handshake for o_frame_data
//   o_frame_data         last successful frame
//   o_err_timeout        sticky watchdog timeout flag
//   o_overflow           sticky flag: a success arrived while a frame was pending
//   o_ok_cnt, o_err_cnt  successful / failed symbols, wrapping
//   o_drop_cnt           triggers ignored while busy, saturating at 255
module ofdm_rx_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_trigger,
    input  logic        i_err_clear,
    output logic        o_fft_start,
    input  logic        i_fft_done,
    input  logic        i_fft_ce,
    input  logic        i_fft_oce,
    input  logic        i_fft_wre,
    input  logic [10:0] i_fft_ad,
    input  logic [31:0] i_fft_din,
    output logic        o_dem_start,
    input  logic        i_dem_finish,
    input  logic        i_dem_success,
    input  logic [95:0] i_dem_res,
    output logic        o_dem_clear,
    input  logic        i_dem_ce,
    input  logic        i_dem_oce,
    input  logic [10:0] i_dem_ad,
    output logic        o_ram_ce,
    output logic        o_ram_oce,
    output logic        o_ram_wre,
    output logic [10:0] o_ram_ad,
    output logic [31:0] o_ram_din,
    output logic        o_busy,
    output logic        o_frame_valid,
    input  logic        i_frame_ready,
    output logic [95:0] o_frame_data,
    output logic        o_err_timeout,
    output logic        o_overflow,
    output logic [15:0] o_ok_cnt,
    output logic [15:0] o_err_cnt,
    output logic [7:0]  o_drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FFT_RUN = 2'd1,
        S_DEM_RUN = 2'd2,
        S_CLEAR   = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_fft_start;
    logic        r_dem_start;
    logic        r_dem_clear;
    logic        r_frame_valid;
    logic [95:0] r_frame_data;
    logic        r_err_timeout;
    logic        r_overflow;
    logic [15:0] r_ok_cnt;
    logic [15:0] r_err_cnt;
    logic [7:0]  r_drop_cnt;

    logic w_timer_end;
    logic w_fft_done;
    logic w_finish;
    logic w_success;
    logic w_fail;
    logic w_timeout_evt;
    logic w_drop;
    logic w_load;
    logic w_ovf_set;

    // Completion has priority over the watchdog, so the timeout events are
    // qualified with the absence of the phase's completion input.
    assign w_timer_end   = (r_timer == (TIMEOUT_CYCLES - 16'd1));
    assign w_fft_done    = (r_state == S_FFT_RUN) && i_fft_done;
    assign w_finish      = (r_state == S_DEM_RUN) && i_dem_finish;
    assign w_success     = w_finish && i_dem_success;
    assign w_fail        = w_finish && !i_dem_success;
    assign w_timeout_evt = w_timer_end &&
                           (((r_state == S_FFT_RUN) && !i_fft_done) ||
                            ((r_state == S_DEM_RUN) && !i_dem_finish));
    assign w_drop        = i_trigger && (r_state != S_IDLE);

    // A pending frame that is being consumed this cycle frees the register
    // for the new result; otherwise the old frame is kept and flagged.
    assign w_load        = w_success && (!r_frame_valid || i_frame_ready);
    assign w_ovf_set     = w_success && r_frame_valid && !i_frame_ready;

    // Sequencer: state, watchdog and the three start/clear pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= 16'd0;
            r_fft_start <= 1'b0;
            r_dem_start <= 1'b0;
            r_dem_clear <= 1'b0;
        end else begin
            r_fft_start <= 1'b0;
            r_dem_start <= 1'b0;
            r_dem_clear <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_trigger) begin
                        r_fft_start <= 1'b1;
                        r_timer     <= 16'd0;
                        r_state     <= S_FFT_RUN;
                    end
                end
                S_FFT_RUN: begin
                    if (i_fft_done) begin
                        r_dem_start <= 1'b1;
                        r_timer     <= 16'd0;
                        r_state     <= S_DEM_RUN;
                    end else if (w_timer_end) begin
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer     <= r_timer + 16'd1;
                    end
                end
                S_DEM_RUN: begin
                    if (i_dem_finish) begin
                        r_dem_clear <= 1'b1;
                        r_state     <= S_CLEAR;
                    end else if (w_timer_end) begin
                        // Abort the demodulator so it does not hold stale status.
                        r_dem_clear <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_timer     <= r_timer + 16'd1;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output frame register, sticky flags and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_valid <= 1'b0;
            r_frame_data  <= 96'd0;
            r_err_timeout <= 1'b0;
            r_overflow    <= 1'b0;
            r_ok_cnt      <= 16'd0;
            r_err_cnt     <= 16'd0;
            r_drop_cnt    <= 8'd0;
        end else begin
            if (w_load) begin
                r_frame_data  <= i_dem_res;
                r_frame_valid <= 1'b1;
            end else if (r_frame_valid && i_frame_ready) begin
                r_frame_valid <= 1'b0;
            end

            // Set has priority over clear on both sticky flags.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (i_err_clear) begin
                r_overflow <= 1'b0;
            end

            if (w_timeout_evt) begin
                r_err_timeout <= 1'b1;
            end else if (i_err_clear) begin
                r_err_timeout <= 1'b0;
            end

            if (w_success) begin
                r_ok_cnt <= r_ok_cnt + 16'd1;
            end
            if (w_fail) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // BSRAM port ownership follows the state register directly, so an
    // asynchronous reset releases the port without waiting for a clock.
    always_comb begin
        o_ram_ce  = 1'b0;
        o_ram_oce = 1'b0;
        o_ram_wre = 1'b0;
        o_ram_ad  = 11'd0;
        o_ram_din = 32'd0;
        case (r_state)
            S_FFT_RUN: begin
                o_ram_ce  = i_fft_ce;
                o_ram_oce = i_fft_oce;
                o_ram_wre = i_fft_wre;
                o_ram_ad  = i_fft_ad;
                o_ram_din = i_fft_din;
            end
            S_DEM_RUN: begin
                o_ram_ce  = i_dem_ce;
                o_ram_oce = i_dem_oce;
                o_ram_ad  = i_dem_ad;
            end
            default: begin
                o_ram_ce  = 1'b0;
            end
        endcase
    end

    assign o_fft_start   = r_fft_start;
    assign o_dem_start   = r_dem_start;
    assign o_dem_clear   = r_dem_clear;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_valid = r_frame_valid;
    assign o_frame_data  = r_frame_data;
    assign o_err_timeout = r_err_timeout;
    assign o_overflow    = r_overflow;
    assign o_ok_cnt      = r_ok_cnt;
    assign o_err_cnt     = r_err_cnt;
    assign o_drop_cnt    = r_drop_cnt;

endmodule
